// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the fetch sequencer:
//     state_e   : fetch FSM states (S_OP, S_IMM, S_TGT)
//     kind_e    : instruction word classification (PLAIN, IMM16, BRANCH)
//     classify  : opcode word -> kind_e
//   Branch opcode layout: [15:13]=BRANCH_PREFIX, [NEGATE_BIT]=invert test,
//   [COND_MSB:COND_LSB]=index into the condition flag vector.
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    S_OP  = 2'd0,
    S_IMM = 2'd1,
    S_TGT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    K_PLAIN  = 2'd0,
    K_IMM16  = 2'd1,
    K_BRANCH = 2'd2
  } kind_e;

  localparam logic [2:0] BRANCH_PREFIX = 3'b111;
  localparam logic [9:0] IMM16_SRC     = 10'h3a0;
  localparam int         COND_MSB      = 4;
  localparam int         COND_LSB      = 0;
  localparam int         NEGATE_BIT    = 10;

  // Branch prefix wins over the imm16 source pattern.
  function automatic kind_e classify(input logic [15:0] w);
    if (w[15:13] == BRANCH_PREFIX) return K_BRANCH;
    else if (w[9:0] == IMM16_SRC)  return K_IMM16;
    else                           return K_PLAIN;
  endfunction

endpackage

// File: rtl/fetch_branch_cond.sv
// -----------------------------------------------------------------------------
// fetch_branch_cond
//   Combinational branch resolution: selects one live condition flag and
//   optionally inverts it.
//   Ports:
//     cond_flags [NCOND-1:0] in  : live condition flags
//     cond_sel   [4:0]       in  : flag index from the branch opcode
//     negate                 in  : invert the selected flag ("bn" form)
//     taken                  out : branch is taken
// -----------------------------------------------------------------------------
module fetch_branch_cond #(
  parameter int NCOND = 32
) (
  input  logic [NCOND-1:0] cond_flags,
  input  logic [4:0]       cond_sel,
  input  logic             negate,
  output logic             taken
);

  // Widen to the full 5-bit index space; indices past NCOND read as 0.
  logic [31:0] flags_ext;

  for (genvar i = 0; i < 32; i++) begin : g_ext
    if (i < NCOND) begin : g_live
      assign flags_ext[i] = cond_flags[i];
    end else begin : g_zero
      assign flags_ext[i] = 1'b0;
    end
  end

  assign taken = flags_ext[cond_sel] ^ negate;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Program counter and instruction fetch. Drives the code ROM address from
//   the PC register, reads the combinational ROM word in the same cycle,
//   assembles one/two-word instructions and resolves branches internally.
//   Only non-branch instructions are issued downstream.
//
//   Ports:
//     clk, reset            : clock, asynchronous active-high reset
//     code_addr  [PC_WIDTH] : ROM address (= pc register)
//     code_data  [16]       : ROM word at code_addr
//     cond_flags [NCOND]    : branch condition flags
//     exec_stall            : freeze all state and outputs
//     instr_out/imm_out     : issued opcode and trailing immediate (0 if none)
//     instr_valid           : one pulse per issue (held while stalled)
//     pc_out     [PC_WIDTH] : address of the issued opcode
//   Optional (FETCH_BREAKPOINT_EN defined):
//     bp_addr, bp_arm, bp_resume in; bp_hit out.
//
//   Handshake: instr_valid=1 after an edge means instr_out/imm_out/pc_out hold
//   a new instruction; the first following edge with exec_stall=0 consumes it.
//   With exec_stall=1 nothing in this block changes on that edge.
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  NCOND        = 32
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] code_addr,
  input  logic [15:0]         code_data,
  input  logic [NCOND-1:0]    cond_flags,
  input  logic                exec_stall,
`ifdef FETCH_BREAKPOINT_EN
  input  logic [PC_WIDTH-1:0] bp_addr,
  input  logic                bp_arm,
  input  logic                bp_resume,
  output logic                bp_hit,
`endif
  output logic [15:0]         instr_out,
  output logic [15:0]         imm_out,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc_out
);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         op_q, op_d;
  logic [PC_WIDTH-1:0] op_addr_q, op_addr_d;
  logic [15:0]         instr_out_q, instr_out_d;
  logic [15:0]         imm_out_q, imm_out_d;
  logic                instr_valid_q, instr_valid_d;
  logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic                taken;
  logic                fetch_en;

`ifdef FETCH_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;
  // Set by a resume so the same address does not re-trigger immediately.
  logic bp_skip_q, bp_skip_d;
`endif

  fetch_branch_cond #(.NCOND(NCOND)) u_cond (
    .cond_flags (cond_flags),
    .cond_sel   (op_q[COND_MSB:COND_LSB]),
    .negate     (op_q[NEGATE_BIT]),
    .taken      (taken)
  );

  assign pc_inc = pc_q + PC_WIDTH'(1);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    op_d          = op_q;
    op_addr_d     = op_addr_q;
    instr_out_d   = instr_out_q;
    imm_out_d     = imm_out_q;
    instr_valid_d = instr_valid_q;
    pc_out_d      = pc_out_q;
    fetch_en      = 1'b1;
`ifdef FETCH_BREAKPOINT_EN
    bp_hit_d  = bp_hit_q;
    bp_skip_d = bp_skip_q;
`endif

    if (!exec_stall) begin
      instr_valid_d = 1'b0;

`ifdef FETCH_BREAKPOINT_EN
      if (pc_q != bp_addr) bp_skip_d = 1'b0;
      if (bp_hit_q) begin
        if (bp_resume) begin
          bp_hit_d  = 1'b0;
          bp_skip_d = 1'b1;
        end else begin
          fetch_en = 1'b0;
        end
      end else if (state_q == S_OP && bp_arm && pc_q == bp_addr && !bp_skip_q) begin
        bp_hit_d = 1'b1;
        fetch_en = 1'b0;
      end
`endif

      if (fetch_en) begin
        case (state_q)
          S_OP: begin
            op_d      = code_data;
            op_addr_d = pc_q;
            pc_d      = pc_inc;
            case (classify(code_data))
              K_IMM16:  state_d = S_IMM;
              K_BRANCH: state_d = S_TGT;
              default: begin
                instr_out_d   = code_data;
                imm_out_d     = 16'h0000;
                instr_valid_d = 1'b1;
                pc_out_d      = pc_q;
              end
            endcase
          end
          S_IMM: begin
            instr_out_d   = op_q;
            imm_out_d     = code_data;
            instr_valid_d = 1'b1;
            pc_out_d      = op_addr_q;
            pc_d          = pc_inc;
            state_d       = S_OP;
          end
          S_TGT: begin
            pc_d    = taken ? PC_WIDTH'(code_data) : pc_inc;
            state_d = S_OP;
          end
          default: state_d = S_OP;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_OP;
      pc_q          <= RESET_VECTOR;
      op_q          <= 16'h0000;
      op_addr_q     <= '0;
      instr_out_q   <= 16'h0000;
      imm_out_q     <= 16'h0000;
      instr_valid_q <= 1'b0;
      pc_out_q      <= '0;
`ifdef FETCH_BREAKPOINT_EN
      bp_hit_q      <= 1'b0;
      bp_skip_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      op_q          <= op_d;
      op_addr_q     <= op_addr_d;
      instr_out_q   <= instr_out_d;
      imm_out_q     <= imm_out_d;
      instr_valid_q <= instr_valid_d;
      pc_out_q      <= pc_out_d;
`ifdef FETCH_BREAKPOINT_EN
      bp_hit_q      <= bp_hit_d;
      bp_skip_q     <= bp_skip_d;
`endif
    end
  end

  assign code_addr   = pc_q;
  assign instr_out   = instr_out_q;
  assign imm_out     = imm_out_q;
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_out_q;
`ifdef FETCH_BREAKPOINT_EN
  assign bp_hit      = bp_hit_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] code_addr;
  logic [15:0] code_data;
  logic [31:0] cond_flags = 32'h0000_0020;
  logic        exec_stall = 1'b0;
  logic [15:0] instr_out;
  logic [15:0] imm_out;
  logic        instr_valid;
  logic [15:0] pc_out;
`ifdef FETCH_BREAKPOINT_EN
  logic [15:0] bp_addr   = 16'h0;
  logic        bp_arm    = 1'b0;
  logic        bp_resume = 1'b0;
  logic        bp_hit;
`endif

  logic [15:0] rom [0:65535];
  logic [47:0] exp_q [$];
  logic [47:0] exp_e;
  int checks = 0;
  int passes = 0;

  assign code_data = rom[code_addr];

  // clock / reset
  always #5 clk = ~clk;

  fetch_sequencer #(.PC_WIDTH(16), .RESET_VECTOR(16'h0000), .NCOND(32)) dut (
    .clk         (clk),
    .reset       (rst),
    .code_addr   (code_addr),
    .code_data   (code_data),
    .cond_flags  (cond_flags),
    .exec_stall  (exec_stall),
`ifdef FETCH_BREAKPOINT_EN
    .bp_addr     (bp_addr),
    .bp_arm      (bp_arm),
    .bp_resume   (bp_resume),
    .bp_hit      (bp_hit),
`endif
    .instr_out   (instr_out),
    .imm_out     (imm_out),
    .instr_valid (instr_valid),
    .pc_out      (pc_out)
  );

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exec_stall = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Unconditional branch at 0 so each scenario starts at its own region.
  task automatic load_jump(input logic [15:0] target);
    rom[0] = 16'he005;
    rom[1] = target;
  endtask

  task automatic test_reset();
    rom[0] = 16'h2a01;
    rom[1] = 16'h1111;
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (code_addr !== 16'h0) $display("FAIL rst_addr: got %h want 0000", code_addr); else passes++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid); else passes++;
    checks++; if (instr_out !== 16'h0) $display("FAIL rst_instr: got %h want 0000", instr_out); else passes++;
    checks++; if (imm_out !== 16'h0) $display("FAIL rst_imm: got %h want 0000", imm_out); else passes++;
    checks++; if (pc_out !== 16'h0) $display("FAIL rst_pc_out: got %h want 0000", pc_out); else passes++;
    rst = 1'b0;
    exp_q.push_back({16'h2a01, 16'h0000, 16'h0000});
    exp_q.push_back({16'h1111, 16'h0000, 16'h0001});
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL reset_issue%0d: valid %b want 1", i, instr_valid);
      else begin
        exp_e = exp_q.pop_front();
        if ({instr_out, imm_out, pc_out} !== exp_e) $display("FAIL reset_issue%0d: got %h want %h", i, {instr_out, imm_out, pc_out}, exp_e);
        else passes++;
      end
      checks++; if (code_addr !== 16'(i + 1)) $display("FAIL reset_pc%0d: got %h want %h", i, code_addr, 16'(i + 1)); else passes++;
    end
  endtask

  task automatic test_imm16();
    load_jump(16'h000c);
    rom[16'h0c] = 16'h23a0;
    rom[16'h0d] = 16'h0055;
    rom[16'h0e] = 16'h2b00;
    do_reset();
    exp_q.push_back({16'h23a0, 16'h0055, 16'h000c});
    exp_q.push_back({16'h2b00, 16'h0000, 16'h000e});
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 3) begin
        checks++; if (code_addr !== 16'h000e) $display("FAIL imm16_next_pc: got %h want 000e", code_addr); else passes++;
      end
      if (instr_valid) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL imm16_issue: unexpected %h", {instr_out, imm_out, pc_out});
        else begin
          exp_e = exp_q.pop_front();
          if ({instr_out, imm_out, pc_out} !== exp_e) $display("FAIL imm16_issue: got %h want %h", {instr_out, imm_out, pc_out}, exp_e);
          else passes++;
        end
      end
    end
    checks++; if (exp_q.size() != 0) $display("FAIL imm16_missing: got %0d left want 0", exp_q.size()); else passes++;
    checks++; if (code_addr !== 16'h000f) $display("FAIL imm16_pc: got %h want 000f", code_addr); else passes++;
  endtask

  task automatic test_branch();
    load_jump(16'h0016);
    rom[16'h16] = 16'he005;
    rom[16'h17] = 16'h0004;
    rom[16'h04] = 16'h2c04;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b0) $display("FAIL branch_novalid%0d: got %b want 0", i, instr_valid); else passes++;
    end
    checks++; if (code_addr !== 16'h0004) $display("FAIL branch_target: got %h want 0004", code_addr); else passes++;
    exp_q.push_back({16'h2c04, 16'h0000, 16'h0004});
    tick();
    checks++;
    if (instr_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL branch_issue: valid %b want 1", instr_valid);
    else begin
      exp_e = exp_q.pop_front();
      if ({instr_out, imm_out, pc_out} !== exp_e) $display("FAIL branch_issue: got %h want %h", {instr_out, imm_out, pc_out}, exp_e);
      else passes++;
    end
    // Branch to its own address: pc alternates, nothing issues.
    load_jump(16'h0020);
    rom[16'h20] = 16'he005;
    rom[16'h21] = 16'h0020;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b0) $display("FAIL loop_novalid%0d: got %b want 0", i, instr_valid); else passes++;
    end
    checks++; if (code_addr !== 16'h0020) $display("FAIL loop_pc: got %h want 0020", code_addr); else passes++;
  endtask

  task automatic test_branch_cond();
    logic [15:0] want_pc;
    load_jump(16'h000a);
    rom[16'h0a] = 16'he402;
    rom[16'h0b] = 16'h0008;
    rom[16'h08] = 16'h2d08;
    rom[16'h0c] = 16'h2d0c;
    for (int pass = 0; pass < 2; pass++) begin
      // bn on flag 2: flag set -> fall through, clear -> taken.
      cond_flags = (pass == 0) ? 32'h0000_0024 : 32'h0000_0020;
      want_pc = (pass == 0) ? 16'h000c : 16'h0008;
      do_reset();
      repeat (4) tick();
      checks++; if (code_addr !== want_pc) $display("FAIL bn_pc%0d: got %h want %h", pass, code_addr, want_pc); else passes++;
      exp_q.push_back({(pass == 0) ? 16'h2d0c : 16'h2d08, 16'h0000, want_pc});
      // Flags outside S_TGT must not matter.
      cond_flags = $urandom_range(0, 65535) | 32'h20;
      tick();
      checks++;
      if (instr_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL bn_issue%0d: valid %b want 1", pass, instr_valid);
      else begin
        exp_e = exp_q.pop_front();
        if ({instr_out, imm_out, pc_out} !== exp_e) $display("FAIL bn_issue%0d: got %h want %h", pass, {instr_out, imm_out, pc_out}, exp_e);
        else passes++;
      end
    end
    cond_flags = 32'h0000_0020;
  endtask

  task automatic test_stall();
    load_jump(16'h0030);
    rom[16'h30] = 16'h2e30;
    rom[16'h31] = 16'h23a0;
    rom[16'h32] = 16'h0077;
    rom[16'h33] = 16'h2e33;
    do_reset();
    repeat (2) tick();
    exp_q.push_back({16'h2e30, 16'h0000, 16'h0030});
    exp_q.push_back({16'h23a0, 16'h0077, 16'h0031});
    exp_q.push_back({16'h2e33, 16'h0000, 16'h0033});
    tick();
    exp_e = exp_q.pop_front();
    checks++; if (instr_valid !== 1'b1 || {instr_out, imm_out, pc_out} !== exp_e) $display("FAIL stall_issue0: got %b %h want 1 %h", instr_valid, {instr_out, imm_out, pc_out}, exp_e); else passes++;
    exec_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b1 || {instr_out, imm_out, pc_out} !== exp_e) $display("FAIL stall_hold%0d: got %b %h want 1 %h", i, instr_valid, {instr_out, imm_out, pc_out}, exp_e); else passes++;
      checks++; if (code_addr !== 16'h0031) $display("FAIL stall_pc%0d: got %h want 0031", i, code_addr); else passes++;
    end
    exec_stall = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b0) $display("FAIL stall_consumed: got %b want 0", instr_valid); else passes++;
    exec_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b0 || code_addr !== 16'h0032) $display("FAIL stall_imm%0d: got %b %h want 0 0032", i, instr_valid, code_addr); else passes++;
    end
    exec_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL stall_issue%0d: valid %b want 1", i + 1, instr_valid);
      else begin
        exp_e = exp_q.pop_front();
        if ({instr_out, imm_out, pc_out} !== exp_e) $display("FAIL stall_issue%0d: got %h want %h", i + 1, {instr_out, imm_out, pc_out}, exp_e);
        else passes++;
      end
    end
  endtask

  task automatic test_wrap();
    rom[0] = 16'h1234;
    rom[1] = 16'he005;
    rom[2] = 16'hffff;
    rom[16'hffff] = 16'h23a0;
    do_reset();
    exp_q.push_back({16'h1234, 16'h0000, 16'h0000});
    exp_q.push_back({16'h23a0, 16'h1234, 16'hffff});
    for (int i = 0; i < 5; i++) begin
      tick();
      if (instr_valid) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL wrap_issue: unexpected %h", {instr_out, imm_out, pc_out});
        else begin
          exp_e = exp_q.pop_front();
          if ({instr_out, imm_out, pc_out} !== exp_e) $display("FAIL wrap_issue: got %h want %h", {instr_out, imm_out, pc_out}, exp_e);
          else passes++;
        end
      end
    end
    checks++; if (exp_q.size() != 0) $display("FAIL wrap_missing: got %0d left want 0", exp_q.size()); else passes++;
    checks++; if (code_addr !== 16'h0001) $display("FAIL wrap_pc: got %h want 0001", code_addr); else passes++;
  endtask

  task automatic test_reset_in_tgt();
    do_reset();
    repeat (2) tick();
    rst = 1'b1;
    #1;
    checks++; if (code_addr !== 16'h0000 || instr_valid !== 1'b0) $display("FAIL tgt_reset: got %h %b want 0000 0", code_addr, instr_valid); else passes++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back({16'h1234, 16'h0000, 16'h0000});
    tick();
    checks++;
    if (instr_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL tgt_restart: valid %b want 1", instr_valid);
    else begin
      exp_e = exp_q.pop_front();
      if ({instr_out, imm_out, pc_out} !== exp_e) $display("FAIL tgt_restart: got %h want %h", {instr_out, imm_out, pc_out}, exp_e);
      else passes++;
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) rom[a] = 16'h0000;
    test_reset();
    test_imm16();
    test_branch();
    test_branch_cond();
    test_stall();
    test_wrap();
    test_reset_in_tgt();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
